// File: rtl/sram_model_pkg.sv
// Shared definitions for the 1RW/1R masked-write SRAM model: mask-lane
// derivation, parameter legality helpers and port-kind decoding.
package sram_model_pkg;

  typedef enum logic {
    PORT_RW = 1'b0,
    PORT_R  = 1'b1
  } port_kind_e;

  function automatic int num_wmasks(input int data_width, input int write_size);
    int lanes;
    if (write_size > 32'sd0) begin
      lanes = data_width / write_size;
    end else begin
      lanes = 32'sd0;
    end
    return lanes;
  endfunction

  function automatic bit read_latency_legal(input int latency);
    return (latency == 32'sd1) || (latency == 32'sd2);
  endfunction

  function automatic logic port_reads(input port_kind_e kind, input logic csb, input logic web);
    logic rd;
    case (kind)
      PORT_RW: rd = !csb && web;
      PORT_R:  rd = !csb;
      default: rd = 1'b0;
    endcase
    return rd;
  endfunction

  function automatic logic port_writes(input port_kind_e kind, input logic csb, input logic web);
    logic wr;
    case (kind)
      PORT_RW: wr = !csb && !web;
      PORT_R:  wr = 1'b0;
      default: wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/sram_1rw1r_wmask_if.sv
// Bus bundle for the 1RW/1R SRAM: port 0 read/write, port 1 read-only,
// plus the collision and out-of-range status pulses.
interface sram_1rw1r_wmask_if
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int WRITE_SIZE = 8
) ();

  localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE);

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  collision;
  logic                  oob;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout1, collision, oob
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout1, collision, oob
  );

endinterface

// File: rtl/sram_read_stage.sv
// One read port's output path: a single output register, or a capture
// register plus output register, holding its value when no read is taken.
module sram_read_stage
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] dout_r;

  generate
    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
      $fatal(1, "sram_read_stage: READ_LATENCY must be 1 or 2");
    end

    if (READ_LATENCY == 1) begin : g_lat1
      // Output register loads only on a taken read, otherwise holds
      always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
          dout_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
          dout_r <= rd_data;
        end
      end
    end else begin : g_lat2
      logic                  pipe_vld_r;
      logic [DATA_WIDTH-1:0] pipe_data_r;

      // Capture stage tags its data valid; reset drops any read in flight
      always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
          pipe_vld_r  <= 1'b0;
          pipe_data_r <= {DATA_WIDTH{1'b0}};
          dout_r      <= {DATA_WIDTH{1'b0}};
        end else begin
          pipe_vld_r <= rd_en;
          if (rd_en) begin
            pipe_data_r <= rd_data;
          end
          if (pipe_vld_r) begin
            dout_r <= pipe_data_r;
          end
        end
      end
    end
  endgenerate

  assign dout = dout_r;

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural 1RW/1R SRAM with per-lane write mask, same-address collision
// reporting and out-of-range detection; read paths live in sram_read_stage.
module sram_1rw1r_wmask
  import sram_model_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int WRITE_SIZE   = 8,
  parameter int READ_LATENCY = 1,
  parameter int VERBOSE      = 1
) (
  input logic               clk0,
  input logic               rst0,
  sram_1rw1r_wmask_if.slave bus
);

  localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WRITE_SIZE);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  generate
    if (WRITE_SIZE < 1 || DATA_WIDTH < 1 || (DATA_WIDTH % WRITE_SIZE) != 0) begin : g_bad_wsize
      $fatal(1, "sram_1rw1r_wmask: DATA_WIDTH must be a positive multiple of WRITE_SIZE");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_awidth
      $fatal(1, "sram_1rw1r_wmask: ADDR_WIDTH out of range");
    end else if (RAM_DEPTH < 2 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
      $fatal(1, "sram_1rw1r_wmask: RAM_DEPTH must lie in 2..2**ADDR_WIDTH");
    end
    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
      $fatal(1, "sram_1rw1r_wmask: READ_LATENCY must be 1 or 2");
    end
    if (VERBOSE < 0 || VERBOSE > 1) begin : g_bad_verbose
      $fatal(1, "sram_1rw1r_wmask: VERBOSE must be 0 or 1");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

  logic                  sel0_s;
  logic                  in0_range_s;
  logic                  in1_range_s;
  logic                  rd0_en_s;
  logic                  rd1_en_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rd0_data_s;
  logic [DATA_WIDTH-1:0] rd1_data_s;
  logic [DATA_WIDTH-1:0] dout0_s;
  logic [DATA_WIDTH-1:0] dout1_s;
  logic                  collision_r;
  logic                  oob_r;

  // Request decode and pre-write array fetch; out-of-range reads return zero
  always_comb begin
    sel0_s      = !bus.csb0;
    in0_range_s = ({1'b0, bus.addr0} < DEPTH_LIMIT);
    in1_range_s = ({1'b0, bus.addr1} < DEPTH_LIMIT);
    rd0_en_s    = port_reads(PORT_RW, bus.csb0, bus.web0);
    rd1_en_s    = port_reads(PORT_R, bus.csb1, 1'b1);
    wr_en_s     = port_writes(PORT_RW, bus.csb0, bus.web0) && in0_range_s;
    rd0_data_s  = {DATA_WIDTH{1'b0}};
    rd1_data_s  = {DATA_WIDTH{1'b0}};
    if (in0_range_s) begin
      rd0_data_s = mem_r[bus.addr0];
    end else begin
      rd0_data_s = {DATA_WIDTH{1'b0}};
    end
    if (in1_range_s) begin
      rd1_data_s = mem_r[bus.addr1];
    end else begin
      rd1_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Masked lane update; contents survive reset, but no write lands while it is high
  always_ff @(posedge clk0 or posedge rst0) begin
    if (!rst0 && wr_en_s) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (bus.wmask0[i]) begin
          mem_r[bus.addr0][i*WRITE_SIZE +: WRITE_SIZE] <= bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
        end
      end
    end
  end

  // One-cycle status pulses describing the accesses taken at this edge
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      collision_r <= 1'b0;
      oob_r       <= 1'b0;
    end else begin
      collision_r <= wr_en_s && rd1_en_s && (bus.addr0 == bus.addr1);
      oob_r       <= (sel0_s && !in0_range_s) || (rd1_en_s && !in1_range_s);
    end
  end

  sram_read_stage #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd0 (
    .clk0    (clk0),
    .rst0    (rst0),
    .rd_en   (rd0_en_s),
    .rd_data (rd0_data_s),
    .dout    (dout0_s)
  );

  sram_read_stage #(
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_rd1 (
    .clk0    (clk0),
    .rst0    (rst0),
    .rd_en   (rd1_en_s),
    .rd_data (rd1_data_s),
    .dout    (dout1_s)
  );

  assign bus.dout0     = dout0_s;
  assign bus.dout1     = dout1_s;
  assign bus.collision = collision_r;
  assign bus.oob       = oob_r;

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Directed and model-checked bench driving a latency-1 and a latency-2
// instance (12 words of 32 bits, byte mask) with identical stimulus.
module tb_sram_1rw1r_wmask;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [3:0]  addr0;
  logic [31:0] din0;
  logic        csb1;
  logic [3:0]  addr1;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [12];
  logic [31:0] e0_1, e1_1, e0_2, e1_2, pd0, pd1;
  logic        pv0, pv1;

  always #5 clk0 = ~clk0;

  sram_1rw1r_wmask_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_SIZE(8)) bus_l1 ();
  sram_1rw1r_wmask_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WRITE_SIZE(8)) bus_l2 ();

  assign bus_l1.csb0 = csb0;   assign bus_l2.csb0 = csb0;
  assign bus_l1.web0 = web0;   assign bus_l2.web0 = web0;
  assign bus_l1.wmask0 = wmask0; assign bus_l2.wmask0 = wmask0;
  assign bus_l1.addr0 = addr0; assign bus_l2.addr0 = addr0;
  assign bus_l1.din0 = din0;   assign bus_l2.din0 = din0;
  assign bus_l1.csb1 = csb1;   assign bus_l2.csb1 = csb1;
  assign bus_l1.addr1 = addr1; assign bus_l2.addr1 = addr1;

  sram_1rw1r_wmask #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(12), .WRITE_SIZE(8),
                     .READ_LATENCY(1), .VERBOSE(0)) dut_l1 (.clk0(clk0), .rst0(rst0), .bus(bus_l1));
  sram_1rw1r_wmask #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RAM_DEPTH(12), .WRITE_SIZE(8),
                     .READ_LATENCY(2), .VERBOSE(0)) dut_l2 (.clk0(clk0), .rst0(rst0), .bus(bus_l2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [3:0] m0, input logic [3:0] a0,
                       input logic [31:0] d0, input logic c1, input logic [3:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic op(input logic c0, input logic w0, input logic [3:0] m0, input logic [3:0] a0,
                    input logic [31:0] d0, input logic c1, input logic [3:0] a1);
    drive(c0, w0, m0, a0, d0, c1, a1);
    tick();
  endtask

  task automatic idle();
    op(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
  endtask

  // Reference model: predict both instances for one cycle, then compare
  task automatic mcyc(input logic c0, input logic w0, input logic [3:0] m0, input logic [3:0] a0,
                      input logic [31:0] d0, input logic c1, input logic [3:0] a1);
    logic        rd0, rd1, exp_col, exp_oob;
    logic [31:0] r0, r1;
    rd0 = !c0 && w0;
    rd1 = !c1;
    r0  = (a0 < 4'd12) ? ref_mem[a0] : 32'h0;
    r1  = (a1 < 4'd12) ? ref_mem[a1] : 32'h0;
    exp_col = !c0 && !w0 && !c1 && (a0 == a1) && (a0 < 4'd12);
    exp_oob = (!c0 && a0 >= 4'd12) || (!c1 && a1 >= 4'd12);
    if (pv0) e0_2 = pd0;
    if (pv1) e1_2 = pd1;
    pv0 = rd0; pd0 = r0;
    pv1 = rd1; pd1 = r1;
    if (rd0) e0_1 = r0;
    if (rd1) e1_1 = r1;
    if (!c0 && !w0 && a0 < 4'd12) begin
      for (int i = 0; i < 4; i++) begin
        if (m0[i]) ref_mem[a0][i*8 +: 8] = d0[i*8 +: 8];
      end
    end
    op(c0, w0, m0, a0, d0, c1, a1);
    chk("rnd_l1_dout0", bus_l1.dout0, e0_1);
    chk("rnd_l1_dout1", bus_l1.dout1, e1_1);
    chk("rnd_l2_dout0", bus_l2.dout0, e0_2);
    chk("rnd_l2_dout1", bus_l2.dout1, e1_2);
    chk("rnd_l1_col", bus_l1.collision, {31'd0, exp_col});
    chk("rnd_l2_col", bus_l2.collision, {31'd0, exp_col});
    chk("rnd_l1_oob", bus_l1.oob, {31'd0, exp_oob});
    chk("rnd_l2_oob", bus_l2.oob, {31'd0, exp_oob});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
    rst0 = 1'b0;
    #1 rst0 = 1'b1;
    #2;
    chk("rst_l1_dout0", bus_l1.dout0, 32'h0);
    chk("rst_l2_dout1", bus_l2.dout1, 32'h0);
    chk("rst_l1_col", bus_l1.collision, 32'd0);
    chk("rst_l2_oob", bus_l2.oob, 32'd0);
    tick();
    tick();
    rst0 = 1'b0;

    // Full write then port 1 read of addr 3
    op(1'b0, 1'b0, 4'hF, 4'd3, 32'hDEADBEEF, 1'b1, 4'd0);
    chk("wr_hold_dout0", bus_l1.dout0, 32'h0);
    chk("wr_oob", bus_l1.oob, 32'd0);
    op(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd3);
    chk("full_l1_dout1", bus_l1.dout1, 32'hDEADBEEF);
    chk("full_l2_early", bus_l2.dout1, 32'h0);
    idle();
    chk("full_l2_dout1", bus_l2.dout1, 32'hDEADBEEF);
    chk("full_l1_hold", bus_l1.dout1, 32'hDEADBEEF);

    // Partial mask write over addr 3
    op(1'b0, 1'b0, 4'b0101, 4'd3, 32'h11223344, 1'b1, 4'd0);
    op(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'd0);
    chk("mask_l1_dout0", bus_l1.dout0, 32'hDE22BE44);
    idle();
    chk("mask_l2_dout0", bus_l2.dout0, 32'hDE22BE44);

    // Same-address write/read collision on addr 5
    op(1'b0, 1'b0, 4'hF, 4'd5, 32'h00000001, 1'b1, 4'd0);
    op(1'b0, 1'b0, 4'hF, 4'd5, 32'hCAFEF00D, 1'b0, 4'd5);
    chk("col_l1_dout1", bus_l1.dout1, 32'h00000001);
    chk("col_l1_flag", bus_l1.collision, 32'd1);
    chk("col_l2_flag", bus_l2.collision, 32'd1);
    op(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd5);
    chk("col_after_l1", bus_l1.dout1, 32'hCAFEF00D);
    chk("col_clear", bus_l1.collision, 32'd0);
    chk("col_l2_old", bus_l2.dout1, 32'h00000001);
    idle();
    chk("col_after_l2", bus_l2.dout1, 32'hCAFEF00D);
    op(1'b0, 1'b0, 4'hF, 4'd6, 32'h00000066, 1'b0, 4'd5);
    chk("col_diff_addr", bus_l1.collision, 32'd0);
    op(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'd5);
    chk("col_rd_rd", bus_l1.collision, 32'd0);
    chk("rd_rd_dout0", bus_l1.dout0, 32'hCAFEF00D);

    // Out-of-range accesses and the last in-range word
    op(1'b0, 1'b0, 4'hF, 4'd13, 32'h12345678, 1'b1, 4'd0);
    chk("oob_wr_l1", bus_l1.oob, 32'd1);
    chk("oob_wr_l2", bus_l2.oob, 32'd1);
    op(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd14);
    chk("oob_rd_l1", bus_l1.dout1, 32'h0);
    chk("oob_rd_flag", bus_l1.oob, 32'd1);
    idle();
    chk("oob_rd_l2", bus_l2.dout1, 32'h0);
    chk("oob_clear", bus_l1.oob, 32'd0);
    op(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd5);
    chk("oob_no_change", bus_l1.dout1, 32'hCAFEF00D);
    op(1'b0, 1'b0, 4'hF, 4'd11, 32'h0B0B0B0B, 1'b0, 4'd12);
    chk("edge_rd12_dout1", bus_l1.dout1, 32'h0);
    chk("edge_rd12_oob", bus_l1.oob, 32'd1);
    op(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd11);
    chk("edge_rd11_dout1", bus_l1.dout1, 32'h0B0B0B0B);
    chk("edge_rd11_oob", bus_l1.oob, 32'd0);

    // Reset between read edge and data edge; write attempted during reset
    op(1'b1, 1'b1, 4'h0, 4'd0, 32'h0, 1'b0, 4'd3);
    chk("pre_rst_l1", bus_l1.dout1, 32'hDE22BE44);
    drive(1'b0, 1'b0, 4'hF, 4'd3, 32'hFFFFFFFF, 1'b1, 4'd0);
    rst0 = 1'b1;
    #1;
    chk("rst_async_l1_d1", bus_l1.dout1, 32'h0);
    chk("rst_async_l1_d0", bus_l1.dout0, 32'h0);
    chk("rst_async_l2_d1", bus_l2.dout1, 32'h0);
    tick();
    tick();
    rst0 = 1'b0;
    idle();
    chk("rst_discard_l2", bus_l2.dout1, 32'h0);
    idle();
    chk("rst_discard_l2b", bus_l2.dout1, 32'h0);
    op(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'd3);
    chk("post_rst_l1_d0", bus_l1.dout0, 32'hDE22BE44);
    chk("post_rst_l1_d1", bus_l1.dout1, 32'hDE22BE44);
    idle();
    chk("post_rst_l2_d0", bus_l2.dout0, 32'hDE22BE44);
    chk("post_rst_l2_d1", bus_l2.dout1, 32'hDE22BE44);

    // Model-checked phase: fill every word, then 100 random cycles
    e0_1 = 32'hDE22BE44; e1_1 = 32'hDE22BE44;
    e0_2 = 32'hDE22BE44; e1_2 = 32'hDE22BE44;
    pv0 = 1'b0; pv1 = 1'b0; pd0 = 32'h0; pd1 = 32'h0;
    for (int a = 0; a < 12; a++) begin
      mcyc(1'b0, 1'b0, 4'hF, 4'(a), $urandom, 1'b1, 4'd0);
    end
    for (int n = 0; n < 100; n++) begin
      mcyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_wmask.md
SRAM_1RW1R_WMASK -- requirements
Module: sram_1rw1r_wmask

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, address width.
REQ-003 Parameter RAM_DEPTH, default 1<<ADDR_WIDTH, implemented words; legal range 2..2^ADDR_WIDTH.
REQ-004 Parameter WRITE_SIZE, default 8, mask granularity; DATA_WIDTH SHALL be a multiple; NUM_WMASKS = DATA_WIDTH/WRITE_SIZE.
REQ-005 Parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from sampled read to dout update.
REQ-006 Parameter VERBOSE, default 1, simulation-only access messages; 0 prints warnings only.
REQ-007 clk0  in  1  single clock; all state changes on posedge.
REQ-008 rst0  in  1  asynchronous, active-high reset.
REQ-009 csb0  in  1  port 0 (RW) active-low select.
REQ-010 web0  in  1  port 0 active-low write enable.
REQ-011 wmask0  in  NUM_WMASKS  port 0 write mask, bit i enables din0[i*WRITE_SIZE +: WRITE_SIZE].
REQ-012 addr0  in  ADDR_WIDTH  port 0 address.
REQ-013 din0  in  DATA_WIDTH  port 0 write data.
REQ-014 dout0  out  DATA_WIDTH  port 0 read data.
REQ-015 csb1  in  1  port 1 (R) active-low select.
REQ-016 addr1  in  ADDR_WIDTH  port 1 address.
REQ-017 dout1  out  DATA_WIDTH  port 1 read data.
REQ-018 collision  out  1  same-address port-0-write/port-1-read pulse.
REQ-019 oob  out  1  out-of-range access pulse.

Function
REQ-020 All inputs SHALL be sampled at posedge clk0; operation for edge N uses only edge-N samples.
REQ-021 Port 0 write (csb0=0, web0=0): at edge N, enabled lanes of mem[addr0] take din0; disabled lanes keep old value; wmask0=0 leaves word unchanged.
REQ-022 Port 0 read (csb0=0, web0=1) / port 1 read (csb1=0): read array state before any edge-N write.
REQ-023 READ_LATENCY=1: doutX valid immediately after edge N; =2: after edge N+1 via one extra output register.
REQ-024 doutX SHALL hold its last value on cycles with no read on that port, including port 0 write cycles.
REQ-025 Port 0 write and port 1 read to same in-range address at edge N: dout1 returns pre-write data; write completes; collision=1 for the one cycle after edge N.
REQ-026 collision SHALL be 0 if either port is deselected, port 0 is reading, or addresses differ.
REQ-027 Access with address >= RAM_DEPTH: write dropped, read returns all-zero on that port, oob=1 for one cycle after the edge; either port qualifies.
REQ-028 Back-to-back accesses every cycle SHALL be supported on both ports with no stall.
REQ-029 With VERBOSE=1, each read/write SHALL print time, instance, port, address and data; collision and oob SHALL always print a warning.

Reset
REQ-030 rst0 high SHALL immediately force dout0, dout1, all READ_LATENCY=2 pipeline registers, collision and oob to 0.
REQ-031 While rst0 is high no read or write SHALL occur; array contents SHALL NOT be cleared.
REQ-032 Edges coinciding with rst0 high SHALL be ignored; first operation taken is at the first posedge after deassertion.
REQ-033 Reset mid-pipeline (READ_LATENCY=2) SHALL discard the in-flight read; its data never appears.

Structure
REQ-034 Shared package sram_model_pkg SHALL hold NUM_WMASKS derivation, the READ_LATENCY legality check and the port-kind enumeration (RW, R).
REQ-035 Sub-module sram_read_stage SHALL implement one read port's output register/pipeline and hold behaviour, instantiated once per port.
REQ-036 Illegal parameter combinations SHALL fail at elaboration.

Verification (DATA_WIDTH=32, WRITE_SIZE=8, ADDR_WIDTH=4, RAM_DEPTH=12)
REQ-037 Full write 0xDEADBEEF to addr 3, then port 1 read addr 3 -> dout1=0xDEADBEEF one cycle after read edge (latency 1), two cycles (latency 2).
REQ-038 Over 0xDEADBEEF at addr 3, write din0=0x11223344 wmask0=4'b0101 -> port 0 read addr 3 returns 0xDE22BE44.
REQ-039 Same edge: port 0 writes 0xCAFEF00D to addr 5 (old 0x00000001), port 1 reads addr 5 -> dout1=0x00000001, collision=1 one cycle; next read 0xCAFEF00D, collision=0.
REQ-040 Port 0 write to addr 13 -> oob=1, no array change; port 1 read addr 14 -> dout1=0, oob=1.
REQ-041 Assert rst0 between read edge and data edge (latency 2) -> dout1 stays 0; after release, earlier-written data still readable.
REQ-042 Alternate reads/writes every cycle on both ports for 100 random cycles -> doutX matches reference array model, holds when idle.
